// File: rtl/ps2_frame_rx_if.sv
// PS/2 receiver pin and result bundle: raw keyboard pins in, received byte and status out.
// The slave side is the receiver; the master side drives the pins and observes the results.
interface ps2_frame_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       rx_stb;
    logic       rx_err;
    logic       busy;

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output rx_data,
        output rx_stb,
        output rx_err,
        output busy
    );

    modport master (
        output ps2_clk,
        output ps2_data,
        input  rx_data,
        input  rx_stb,
        input  rx_err,
        input  busy
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronise, glitch-filter ps2_clk, shift 11-bit frames, check odd parity/stop/timeout.
// Pin fall to sample takes 2+FILT cycles; rx_stb/rx_err pulse one cycle after the stop edge; no backpressure, pulses must be taken as they come.
module ps2_frame_rx #(
    parameter int REFCLK = 50000000,
    parameter int FILT   = 8
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    ps2_frame_rx_if.slave  ps2_if
);
    localparam int TOUT = REFCLK / 500;
    localparam int FCW  = $clog2(FILT + 1);
    localparam int TCW  = $clog2(TOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t         state_q, state_d;
    logic           ck_s1_q, ck_s2_q, dt_s1_q, dt_s2_q;
    logic           fclk_q, fclk_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic [TCW-1:0] tout_q, tout_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           stb_q, stb_d;
    logic           err_q, err_d;
    logic           fall;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ck_s1_q   <= 1'b1;
            ck_s2_q   <= 1'b1;
            dt_s1_q   <= 1'b1;
            dt_s2_q   <= 1'b1;
            fclk_q    <= 1'b1;
            fcnt_q    <= '0;
            tout_q    <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            rx_data_q <= '0;
            stb_q     <= 1'b0;
            err_q     <= 1'b0;
            state_q   <= IDLE;
        end else begin
            ck_s1_q   <= ps2_if.ps2_clk;
            ck_s2_q   <= ck_s1_q;
            dt_s1_q   <= ps2_if.ps2_data;
            dt_s2_q   <= dt_s1_q;
            fclk_q    <= fclk_d;
            fcnt_q    <= fcnt_d;
            tout_q    <= tout_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            rx_data_q <= rx_data_d;
            stb_q     <= stb_d;
            err_q     <= err_d;
            state_q   <= state_d;
        end
    end

    // Filtered level flips only after FILT straight samples disagree with it.
    always_comb begin
        fclk_d = fclk_q;
        fcnt_d = '0;
        if (ck_s2_q != fclk_q) begin
            if (fcnt_q == FCW'(FILT - 1)) begin
                fclk_d = ck_s2_q;
            end else begin
                fcnt_d = fcnt_q + FCW'(1);
            end
        end
    end

    assign fall = fclk_q & ~fclk_d;

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        rx_data_d = rx_data_q;
        stb_d     = 1'b0;
        err_d     = 1'b0;
        tout_d    = '0;
        if (state_q != IDLE && !fall) begin
            tout_d = tout_q + TCW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (fall && !dt_s2_q) begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d  = {dt_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dt_s2_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (dt_s2_q && (^{shift_q, par_q})) begin
                        rx_data_d = shift_q;
                        stb_d     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The counter reaches TOUT on the same edge the error pulse is registered.
        if (state_q != IDLE && !fall && tout_q == TCW'(TOUT - 1)) begin
            state_d   = IDLE;
            tout_d    = '0;
            rx_data_d = rx_data_q;
            stb_d     = 1'b0;
            err_d     = 1'b1;
        end
    end

    assign ps2_if.rx_data = rx_data_q;
    assign ps2_if.rx_stb  = stb_q;
    assign ps2_if.rx_err  = err_q;
    assign ps2_if.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: table of whole frames plus glitch, timeout and reset sequences.
module tb_ps2_frame_rx;
    localparam int REFCLK = 500000;
    localparam int FILT   = 8;
    localparam int TOUT   = REFCLK / 500;
    localparam int HALF   = 20;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         exp_stb;
        int         exp_err;
        logic [7:0] exp_rx;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_frame_rx_if bus();

    ps2_frame_rx #(.REFCLK(REFCLK), .FILT(FILT)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .ps2_if   (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int stb_hi  = 0;
    int err_hi  = 0;
    int both_hi = 0;

    always @(negedge clk) begin
        if (bus.rx_stb) stb_hi++;
        if (bus.rx_err) err_hi++;
        if (bus.rx_stb && bus.rx_err) both_hi++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int nbits, input int glitch_bit, output logic busy_mid);
        logic [10:0] bits;
        bits     = {stop, par, d, 1'b0};
        busy_mid = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = bits[i];
            tick(4);
            bus.ps2_clk = 1'b0;
            tick(HALF);
            bus.ps2_clk = 1'b1;
            if (i == 1) busy_mid = bus.busy;
            if (i == glitch_bit) begin
                tick(5);
                bus.ps2_clk = 1'b0;
                tick(3);
                bus.ps2_clk = 1'b1;
                tick(HALF - 8);
            end else begin
                tick(HALF);
            end
        end
        bus.ps2_data = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin
        logic bm;
        int   s0, e0, n;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
        vecs[1] = '{8'hF0, 1'b0, 1'b1, 0, 1, 8'h1C};
        vecs[2] = '{8'h5A, 1'b1, 1'b0, 0, 1, 8'h1C};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1, 0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1, 0, 8'hFF};
        vecs[5] = '{8'h80, 1'b0, 1'b1, 1, 0, 8'h80};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        tick(3);
        check("reset_rx_data", {24'd0, bus.rx_data}, 32'h00);
        check("reset_stb", {31'd0, bus.rx_stb}, 32'd0);
        check("reset_err", {31'd0, bus.rx_err}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        tick(5);

        for (int v = 0; v < 6; v++) begin
            s0 = stb_hi;
            e0 = err_hi;
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, 11, -1, bm);
            tick(30);
            check($sformatf("v%0d_stb", v), stb_hi - s0, vecs[v].exp_stb);
            check($sformatf("v%0d_err", v), err_hi - e0, vecs[v].exp_err);
            check($sformatf("v%0d_rx", v), {24'd0, bus.rx_data}, {24'd0, vecs[v].exp_rx});
            check($sformatf("v%0d_busy_mid", v), {31'd0, bm}, 32'd1);
            check($sformatf("v%0d_busy_end", v), {31'd0, bus.busy}, 32'd0);
        end

        // Short low glitch on ps2_clk in the middle of the data bits.
        s0 = stb_hi;
        e0 = err_hi;
        send_frame(8'h29, 1'b0, 1'b1, 11, 4, bm);
        tick(30);
        check("glitch_stb", stb_hi - s0, 1);
        check("glitch_err", err_hi - e0, 0);
        check("glitch_rx", {24'd0, bus.rx_data}, 32'h29);

        // Start plus four data bits, then the clock stays high.
        s0 = stb_hi;
        e0 = err_hi;
        send_frame(8'h0F, 1'b0, 1'b1, 4, -1, bm);
        bus.ps2_data = 1'b1;
        tick(4);
        bus.ps2_clk = 1'b0;
        n = 0;
        while (n < 4000 && !bus.rx_err) begin
            tick(1);
            n++;
            if (n == HALF) bus.ps2_clk = 1'b1;
            if (n == 2 + FILT + TOUT / 2) check("tout_busy_wait", {31'd0, bus.busy}, 32'd1);
        end
        check("tout_latency", n, 2 + FILT + TOUT);
        check("tout_busy", {31'd0, bus.busy}, 32'd0);
        tick(5);
        check("tout_err", err_hi - e0, 1);
        check("tout_stb", stb_hi - s0, 0);
        check("tout_rx", {24'd0, bus.rx_data}, 32'h29);
        s0 = stb_hi;
        send_frame(8'h5A, 1'b1, 1'b1, 11, -1, bm);
        tick(30);
        check("after_tout_stb", stb_hi - s0, 1);
        check("after_tout_rx", {24'd0, bus.rx_data}, 32'h5A);

        // Reset in the middle of a frame.
        s0 = stb_hi;
        e0 = err_hi;
        send_frame(8'h33, 1'b1, 1'b1, 6, -1, bm);
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_rx", {24'd0, bus.rx_data}, 32'h00);
        check("mid_rst_stb", {31'd0, bus.rx_stb}, 32'd0);
        check("mid_rst_err", {31'd0, bus.rx_err}, 32'd0);
        tick(5);
        rst = 1'b0;
        tick(20);
        check("rst_no_stb", stb_hi - s0, 0);
        check("rst_no_err", err_hi - e0, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1, bm);
        tick(30);
        check("post_rst_stb", stb_hi - s0, 1);
        check("post_rst_err", err_hi - e0, 0);
        check("post_rst_rx", {24'd0, bus.rx_data}, 32'h1C);

        check("never_both", both_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
